// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressable data memory for the MEM stage.
// Supports byte/halfword/word loads and stores with sign or zero extension,
// a fixed access latency behind req/ready/valid, and rejects misaligned or
// out-of-range accesses with err_o instead of touching memory.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic             ready_q;
    logic             valid_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             accept;
    logic             enter_done;

    logic             cur_we;
    logic [1:0]       cur_size;
    logic             cur_uns;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [2:0]       cur_bytes;
    logic [32:0]      cur_last;
    logic             cur_err;

    logic [AW-1:0]    byte_idx [4];
    logic [7:0]       byte_rd  [4];
    logic [31:0]      load_data;

    logic [7:0]       mem [DEPTH_BYTES];

    assign accept  = req_i && ready_q;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

    // Next-state decode: entering DONE is the single point where a store commits
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        enter_done = (state_next == ST_DONE);
    end

    // With single-cycle latency DONE is entered on the accept edge itself, so the
    // live inputs stand in for the request registers that are only loading then
    always_comb begin
        cur_we    = we_q;
        cur_size  = size_q;
        cur_uns   = uns_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == ST_IDLE) begin
            cur_we    = we_i;
            cur_size  = size_i;
            cur_uns   = unsigned_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
        end
    end

    // Access legality: bad size, misalignment, or any touched byte past the end
    always_comb begin
        case (cur_size)
            SIZE_BYTE: cur_bytes = 3'd1;
            SIZE_HALF: cur_bytes = 3'd2;
            default:   cur_bytes = 3'd4;
        endcase
        cur_last = {1'b0, cur_addr} + 33'(cur_bytes) - 33'd1;
        cur_err  = 1'b0;
        if (cur_size == 2'b11) begin
            cur_err = 1'b1;
        end
        if ((cur_size == SIZE_HALF) && cur_addr[0]) begin
            cur_err = 1'b1;
        end
        if ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00)) begin
            cur_err = 1'b1;
        end
        if (cur_last >= 33'(DEPTH_BYTES)) begin
            cur_err = 1'b1;
        end
    end

    // Little-endian gather of the four candidate bytes plus size/sign extension
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_idx[k] = cur_addr[AW-1:0] + AW'(k);
            byte_rd[k]  = mem[byte_idx[k]];
        end
        case (cur_size)
            SIZE_BYTE: begin
                load_data = cur_uns ? {24'd0, byte_rd[0]}
                                    : {{24{byte_rd[0][7]}}, byte_rd[0]};
            end
            SIZE_HALF: begin
                load_data = cur_uns ? {16'd0, byte_rd[1], byte_rd[0]}
                                    : {{16{byte_rd[1][7]}}, byte_rd[1], byte_rd[0]};
            end
            default: begin
                load_data = {byte_rd[3], byte_rd[2], byte_rd[1], byte_rd[0]};
            end
        endcase
    end

    // State register and latency down-counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && accept) begin
                cnt <= CNT_LOAD;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Capture the request on accept; inputs are ignored while busy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // Registered outputs so nothing reaches a port combinationally from an input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= (state_next == ST_IDLE);
            valid_q <= enter_done;
            err_q   <= enter_done && cur_err;
            rdata_q <= (enter_done && !cur_we && !cur_err) ? load_data : 32'd0;
        end
    end

    // Store commit on the DONE-entry edge; a reset on that edge aborts the write
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_done && cur_we && !cur_err) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < cur_bytes) begin
                    mem[byte_idx[k]] <= cur_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
